// File: rtl/brj_pkg.sv
// Shared opcode encodings and instruction field positions for the branch/jump
// resolve pipeline. Nothing here depends on the datapath width.
package brj_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 11;
  localparam int RS_MSB    = 10;
  localparam int RS_LSB    = 8;
  localparam int IMM8_MSB  = 7;
  localparam int IMM11_MSB = 10;

  typedef enum logic [4:0] {
    OP_J    = 5'b00100,
    OP_JR   = 5'b00101,
    OP_JAL  = 5'b00110,
    OP_JALR = 5'b00111,
    OP_BEQZ = 5'b01100,
    OP_BNEZ = 5'b01101,
    OP_BGEZ = 5'b01110,
    OP_BLTZ = 5'b01111
  } opcode_e;

endpackage

// File: rtl/brj_decode.sv
// Combinational decode of one instruction: branch/jump class, link write,
// taken condition and the candidate target address.
module brj_decode
  import brj_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [WIDTH-1:0]   pc_inc,
  input  logic [WIDTH-1:0]   rs_val,
  output logic               is_brj,
  output logic               link_wr,
  output logic               taken,
  output logic [WIDTH-1:0]   target
);

  opcode_e          opcode;
  logic [WIDTH-1:0] imm8_sx;
  logic [WIDTH-1:0] imm11_sx;
  logic             rs_zero;
  logic             rs_neg;

  assign opcode   = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign imm8_sx  = {{(WIDTH-IMM8_MSB-1){instr[IMM8_MSB]}}, instr[IMM8_MSB:0]};
  assign imm11_sx = {{(WIDTH-IMM11_MSB-1){instr[IMM11_MSB]}}, instr[IMM11_MSB:0]};
  assign rs_zero  = (rs_val == '0);
  assign rs_neg   = rs_val[WIDTH-1];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    is_brj  = 1'b0;
    link_wr = 1'b0;
    taken   = 1'b0;
    target  = pc_inc;
    case (opcode)
      OP_BEQZ: begin is_brj = 1'b1; taken = rs_zero;  target = pc_inc + imm8_sx; end
      OP_BNEZ: begin is_brj = 1'b1; taken = !rs_zero; target = pc_inc + imm8_sx; end
      OP_BGEZ: begin is_brj = 1'b1; taken = !rs_neg;  target = pc_inc + imm8_sx; end
      OP_BLTZ: begin is_brj = 1'b1; taken = rs_neg;   target = pc_inc + imm8_sx; end
      OP_J:    begin is_brj = 1'b1; taken = 1'b1; target = pc_inc + imm11_sx; end
      OP_JAL:  begin is_brj = 1'b1; taken = 1'b1; link_wr = 1'b1; target = pc_inc + imm11_sx; end
      OP_JR:   begin is_brj = 1'b1; taken = 1'b1; target = rs_val + imm8_sx; end
      OP_JALR: begin is_brj = 1'b1; taken = 1'b1; link_wr = 1'b1; target = rs_val + imm8_sx; end
      default: ;
    endcase
  end

endmodule

// File: rtl/brj_resolve_pipe.sv
// Two-stage branch/jump resolver: S1 holds decode results, S2 holds the
// resolved next PC and its mismatch against the fetch prediction.
module brj_resolve_pipe
  import brj_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [WIDTH-1:0]   pc_inc,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   pred_npc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dest_addr,
  output logic               taken,
  output logic               is_brj,
  output logic               link_wr,
  output logic               redirect,
  output logic [CNT_W-1:0]   cnt_brj,
  output logic [CNT_W-1:0]   cnt_mispred
);

  logic             dec_is_brj, dec_link_wr, dec_taken;
  logic [WIDTH-1:0] dec_target;

  brj_decode #(.WIDTH(WIDTH)) u_decode (
    .instr   (instr),
    .pc_inc  (pc_inc),
    .rs_val  (rs_val),
    .is_brj  (dec_is_brj),
    .link_wr (dec_link_wr),
    .taken   (dec_taken),
    .target  (dec_target)
  );

  logic             s1_valid_q, s1_valid_d;
  logic             s1_is_brj_q, s1_is_brj_d;
  logic             s1_link_wr_q, s1_link_wr_d;
  logic             s1_taken_q, s1_taken_d;
  logic [WIDTH-1:0] s1_target_q, s1_target_d;
  logic [WIDTH-1:0] s1_pc_inc_q, s1_pc_inc_d;
  logic [WIDTH-1:0] s1_pred_q, s1_pred_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] dest_q, dest_d;
  logic             taken_q, taken_d;
  logic             is_brj_q, is_brj_d;
  logic             link_wr_q, link_wr_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] cnt_brj_q, cnt_brj_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  logic             s1_load, s2_load, accept, out_xfer;
  logic [WIDTH-1:0] s1_dest;

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = rst && s1_load;
    accept   = in_valid && in_ready && !flush;
    out_xfer = s2_valid_q && out_ready;
    s1_dest  = s1_taken_q ? s1_target_q : s1_pc_inc_q;

    s1_valid_d    = s1_valid_q;
    s1_is_brj_d   = s1_is_brj_q;
    s1_link_wr_d  = s1_link_wr_q;
    s1_taken_d    = s1_taken_q;
    s1_target_d   = s1_target_q;
    s1_pc_inc_d   = s1_pc_inc_q;
    s1_pred_d     = s1_pred_q;
    s2_valid_d    = s2_valid_q;
    dest_d        = dest_q;
    taken_d       = taken_q;
    is_brj_d      = is_brj_q;
    link_wr_d     = link_wr_q;
    redirect_d    = redirect_q;
    cnt_brj_d     = cnt_brj_q;
    cnt_mispred_d = cnt_mispred_q;

    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_is_brj_d  = dec_is_brj;
        s1_link_wr_d = dec_link_wr;
        s1_taken_d   = dec_taken;
        s1_target_d  = dec_target;
        s1_pc_inc_d  = pc_inc;
        s1_pred_d    = pred_npc;
      end
    end

    // Output fields only move when S2 may load, which keeps them stable under a stall.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dest_d     = s1_dest;
        taken_d    = s1_taken_q;
        is_brj_d   = s1_is_brj_q;
        link_wr_d  = s1_link_wr_q;
        redirect_d = (s1_dest != s1_pred_q);
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    if (out_xfer && is_brj_q && (cnt_brj_q != '1))
      cnt_brj_d = cnt_brj_q + CNT_W'(1);
    if (out_xfer && redirect_q && (cnt_mispred_q != '1))
      cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_is_brj_q   <= 1'b0;
      s1_link_wr_q  <= 1'b0;
      s1_taken_q    <= 1'b0;
      s1_target_q   <= '0;
      s1_pc_inc_q   <= '0;
      s1_pred_q     <= '0;
      s2_valid_q    <= 1'b0;
      dest_q        <= '0;
      taken_q       <= 1'b0;
      is_brj_q      <= 1'b0;
      link_wr_q     <= 1'b0;
      redirect_q    <= 1'b0;
      cnt_brj_q     <= '0;
      cnt_mispred_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_is_brj_q   <= s1_is_brj_d;
      s1_link_wr_q  <= s1_link_wr_d;
      s1_taken_q    <= s1_taken_d;
      s1_target_q   <= s1_target_d;
      s1_pc_inc_q   <= s1_pc_inc_d;
      s1_pred_q     <= s1_pred_d;
      s2_valid_q    <= s2_valid_d;
      dest_q        <= dest_d;
      taken_q       <= taken_d;
      is_brj_q      <= is_brj_d;
      link_wr_q     <= link_wr_d;
      redirect_q    <= redirect_d;
      cnt_brj_q     <= cnt_brj_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign dest_addr   = dest_q;
  assign taken       = taken_q;
  assign is_brj      = is_brj_q;
  assign link_wr     = link_wr_q;
  assign redirect    = s2_valid_q && redirect_q;
  assign cnt_brj     = cnt_brj_q;
  assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_brj_resolve_pipe.sv
// Self-checking bench for brj_resolve_pipe: directed cases plus a random stream
// scored against a queue-based model computed from the branch rules.
module tb_brj_resolve_pipe;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0]      instr;
  logic [WIDTH-1:0] pc_inc, rs_val, pred_npc, dest_addr;
  logic             taken, is_brj, link_wr, redirect;
  logic [CNT_W-1:0] cnt_brj, cnt_mispred;

  brj_resolve_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_inc(pc_inc), .rs_val(rs_val), .pred_npc(pred_npc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .dest_addr(dest_addr), .taken(taken), .is_brj(is_brj), .link_wr(link_wr),
    .redirect(redirect), .cnt_brj(cnt_brj), .cnt_mispred(cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dest;
    bit taken, is_brj, link_wr, redirect;
    int acc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, delivered = 0;
  int exp_cnt_brj = 0, exp_cnt_mis = 0;
  bit last_acc;
  bit prev_hold = 0;
  logic [WIDTH-1:0] prev_dest;
  logic prev_taken, prev_isb, prev_link, prev_redir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules: signed immediates, wrap-around sums, sign bit as "value >= half range".
  function automatic exp_t model(logic [15:0] ins, logic [WIDTH-1:0] pc, logic [WIDTH-1:0] rs,
                                 logic [WIDTH-1:0] pred);
    exp_t e;
    int op, s8, s11;
    longint half, t;
    bit tk;
    op = int'(ins[15:11]);
    s8 = int'(ins[7:0]);   if (s8 >= 128)   s8 -= 256;
    s11 = int'(ins[10:0]); if (s11 >= 1024) s11 -= 2048;
    half = longint'(1) << (WIDTH - 1);
    e.is_brj = 1; e.link_wr = 0; tk = 1; t = 0;
    case (op)
      12: begin tk = (rs == 0);          t = longint'(pc) + s8; end
      13: begin tk = (rs != 0);          t = longint'(pc) + s8; end
      14: begin tk = (longint'(rs) < half);  t = longint'(pc) + s8; end
      15: begin tk = (longint'(rs) >= half); t = longint'(pc) + s8; end
      4:  t = longint'(pc) + s11;
      6:  begin t = longint'(pc) + s11; e.link_wr = 1; end
      5:  t = longint'(rs) + s8;
      7:  begin t = longint'(rs) + s8; e.link_wr = 1; end
      default: begin e.is_brj = 0; tk = 0; end
    endcase
    e.taken = tk;
    e.dest = tk ? WIDTH'(t) : pc;
    e.redirect = (e.dest != pred);
    e.acc = 0;
    return e;
  endfunction

  // One clock: score the cycle at the falling edge, then advance to just past the rising edge.
  task automatic cycle();
    exp_t h;
    bit exp_ir, exp_ov;
    @(negedge clk);
    exp_ir = (rst === 1'b1) && !(q.size() == 2 && !out_ready);
    exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("cnt_brj", 32'(cnt_brj), 32'(exp_cnt_brj));
    check("cnt_mispred", 32'(cnt_mispred), 32'(exp_cnt_mis));
    if (prev_hold) begin
      check("hold_dest", 32'(dest_addr), 32'(prev_dest));
      check("hold_taken", 32'(taken), 32'(prev_taken));
      check("hold_is_brj", 32'(is_brj), 32'(prev_isb));
      check("hold_link", 32'(link_wr), 32'(prev_link));
      check("hold_redirect", 32'(redirect), 32'(prev_redir));
    end
    if (out_valid && out_ready && q.size() > 0) begin
      h = q.pop_front();
      delivered++;
      check("dest_addr", 32'(dest_addr), 32'(h.dest));
      check("taken", 32'(taken), 32'(h.taken));
      check("is_brj", 32'(is_brj), 32'(h.is_brj));
      check("link_wr", 32'(link_wr), 32'(h.link_wr));
      check("redirect", 32'(redirect), 32'(h.redirect));
      if (h.is_brj && exp_cnt_brj < CNT_MAX) exp_cnt_brj++;
      if (h.redirect && exp_cnt_mis < CNT_MAX) exp_cnt_mis++;
    end
    prev_hold  = out_valid && !out_ready && !flush && rst;
    prev_dest  = dest_addr;
    prev_taken = taken;
    prev_isb   = is_brj;
    prev_link  = link_wr;
    prev_redir = redirect;
    last_acc = in_valid && in_ready && !flush;
    if (flush) q.delete();
    else if (last_acc) begin
      h = model(instr, pc_inc, rs_val, pred_npc);
      h.acc = cyc;
      q.push_back(h);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic offer(input logic [15:0] i, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] rs,
                       input logic [WIDTH-1:0] pred);
    instr = i; pc_inc = pc; rs_val = rs; pred_npc = pred;
  endtask

  // Single instruction through an idle pipe, outputs compared with fixed constants.
  task automatic directed(input string tag, input logic [15:0] i, input logic [WIDTH-1:0] pc,
                          input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] pred,
                          input logic [WIDTH-1:0] e_dest, input bit e_tk, input bit e_link,
                          input bit e_redir);
    out_ready = 1; flush = 0;
    in_valid = 1; offer(i, pc, rs, pred);
    cycle();
    in_valid = 0;
    cycle();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_dest"}, 32'(dest_addr), 32'(e_dest));
    check({tag, "_taken"}, 32'(taken), 32'(e_tk));
    check({tag, "_link"}, 32'(link_wr), 32'(e_link));
    check({tag, "_redirect"}, 32'(redirect), 32'(e_redir));
    cycle();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] ops [8];
    logic [4:0] op;
    int r;
    ops = '{5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b00100, 5'b00101, 5'b00110, 5'b00111};
    r = $urandom_range(0, 9);
    op = (r < 8) ? ops[r] : 5'($urandom);
    return {op, 11'($urandom)};
  endfunction

  task automatic rand_offer();
    exp_t m;
    int r;
    instr  = rand_instr();
    pc_inc = WIDTH'($urandom);
    r = $urandom_range(0, 3);
    rs_val = (r == 0) ? '0 : (r == 1) ? (WIDTH'($urandom) | 16'h8000) : WIDTH'($urandom);
    m = model(instr, pc_inc, rs_val, '0);
    r = $urandom_range(0, 3);
    pred_npc = (r < 2) ? pc_inc : (r == 2) ? m.dest : WIDTH'($urandom);
  endtask

  logic [15:0] stall_instr [4];
  int sent;
  logic [CNT_W-1:0] snap_brj, snap_mis;

  initial begin
    rst = 0; in_valid = 0; flush = 0; out_ready = 1;
    offer('0, '0, '0, '0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_dest", 32'(dest_addr), 32'd0);
    check("rst_cnt_brj", 32'(cnt_brj), 32'd0);
    check("rst_cnt_mispred", 32'(cnt_mispred), 32'd0);
    cycle();
    cycle();
    rst = 1;

    directed("beqz_taken", 16'h600F, 16'hF0F0, 16'h0000, 16'hF0F0, 16'hF0FF, 1, 0, 1);
    check("beqz_cnt_mispred", 32'(cnt_mispred), 32'd1);
    directed("bnez_fall", 16'h6802, 16'hF0F0, 16'h0000, 16'hF0F0, 16'hF0F0, 0, 0, 0);
    directed("j_neg", 16'h27FF, 16'hF0F0, 16'h0000, 16'h0000, 16'hF0EF, 1, 0, 1);
    directed("jalr", 16'h3880, 16'h1234, 16'h1000, 16'h0F80, 16'h0F80, 1, 1, 0);
    directed("beqz_wrap", 16'h6001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    directed("nonbr", 16'h0805, 16'h0042, 16'h0000, 16'h0042, 16'h0042, 0, 0, 0);
    check("dir_cnt_brj", 32'(cnt_brj), 32'd5);

    // Back-to-back stream with a downstream stall.
    for (int i = 0; i < 4; i++) stall_instr[i] = rand_instr();
    sent = 0; delivered = 0;
    for (int k = 0; k < 16; k++) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid = (sent < 4);
      offer(stall_instr[sent % 4], WIDTH'(16'h0100 + 16'(sent)), WIDTH'($urandom), 16'h0100);
      cycle();
      if (last_acc) sent++;
    end
    check("stall_delivered", 32'(delivered), 32'd4);
    check("stall_queue_empty", 32'(q.size()), 32'd0);

    // Flush with an offer while both stages are occupied.
    out_ready = 1; in_valid = 1;
    rand_offer(); cycle();
    rand_offer(); cycle();
    snap_brj = cnt_brj; snap_mis = cnt_mispred;
    out_ready = 0; flush = 1; rand_offer();
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_cnt_brj", 32'(cnt_brj), 32'(snap_brj));
    check("flush_cnt_mispred", 32'(cnt_mispred), 32'(snap_mis));
    for (int k = 0; k < 3; k++) cycle();

    // Random traffic; the small counters also reach saturation here.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      rand_offer();
      cycle();
    end
    flush = 0;
    check("sat_cnt_brj", 32'(cnt_brj), 32'(CNT_MAX));

    // Mid-stream asynchronous reset.
    in_valid = 1; out_ready = 1; rand_offer(); cycle();
    rand_offer(); cycle();
    #3;
    rst = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_dest", 32'(dest_addr), 32'd0);
    check("arst_taken", 32'(taken), 32'd0);
    check("arst_is_brj", 32'(is_brj), 32'd0);
    check("arst_link", 32'(link_wr), 32'd0);
    check("arst_redirect", 32'(redirect), 32'd0);
    check("arst_cnt_brj", 32'(cnt_brj), 32'd0);
    check("arst_cnt_mispred", 32'(cnt_mispred), 32'd0);
    q.delete(); exp_cnt_brj = 0; exp_cnt_mis = 0; prev_hold = 0;
    cycle();
    cycle();
    rst = 1;
    offer(16'h600F, 16'hF0F0, 16'h0000, 16'hF0F0);
    cycle();
    check("post_rst_accept", 32'(last_acc), 32'd1);
    in_valid = 0;
    for (int k = 0; k < 3; k++) cycle();
    check("post_rst_cnt_mispred", 32'(cnt_mispred), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brj_resolve_pipe.md
BRJ_RESOLVE_PIPE -- requirements
Module: brj_resolve_pipe

Interface
REQ-001 Parameter WIDTH, default 16: address/data width, legal range 16..32.
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  block accepts the offer this cycle.
REQ-007 instr  input  16  instruction word; opcode in [15:11], Rs in [10:8].
REQ-008 pc_inc  input  WIDTH  incremented PC of instr.
REQ-009 rs_val  input  WIDTH  value read from register Rs.
REQ-010 pred_npc  input  WIDTH  next PC the fetch stage predicted.
REQ-011 flush  input  1  synchronous kill of all in-flight entries.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 dest_addr  output  WIDTH  resolved next PC.
REQ-015 taken  output  1  control transfer taken.
REQ-016 is_brj  output  1  instruction is a branch or jump.
REQ-017 link_wr  output  1  JAL/JALR writes pc_inc to R7.
REQ-018 redirect  output  1  high with out_valid when dest_addr != pred_npc.
REQ-019 cnt_brj, cnt_mispred  output  CNT_W  statistics counters.

Function
REQ-020 The opcodes SHALL be BEQZ 01100, BNEZ 01101, BGEZ 01110, BLTZ 01111, J 00100, JR 00101, JAL 00110, JALR 00111; any other opcode is a non-branch.
REQ-021 Branch target SHALL be pc_inc + sext(instr[7:0]); J/JAL target SHALL be pc_inc + sext(instr[10:0]); JR/JALR target SHALL be rs_val + sext(instr[7:0]); all sums modulo 2^WIDTH.
REQ-022 Conditions: BEQZ rs_val==0, BNEZ rs_val!=0, BLTZ rs_val[WIDTH-1]==1, BGEZ rs_val[WIDTH-1]==0; jumps are always taken.
REQ-023 When not taken or non-branch, dest_addr SHALL equal pc_inc, taken=0; is_brj=0 for non-branch.
REQ-024 Pipeline SHALL have two stages: S1 registers decode, target and condition; S2 registers dest_addr and the comparison against pred_npc; latency from accept to out_valid is exactly 2 cycles with no backpressure.
REQ-025 Handshake: transfer occurs when valid && ready on the same edge; out_valid and all output fields SHALL hold stable while out_valid && !out_ready.
REQ-026 S2 SHALL load when empty or when out_ready=1; S1 SHALL load when empty or S1 advances; in_ready SHALL equal that S1-load condition, so full throughput of one per cycle is sustained while out_ready=1.
REQ-027 flush SHALL clear both stage valid bits on the next edge and take priority over a simultaneous accept (the offered instruction is dropped, in_ready still reflects REQ-026).
REQ-028 redirect SHALL be out_valid && (dest_addr != pred_npc latched at accept), for branch and non-branch alike.
REQ-029 cnt_brj SHALL increment on each output transfer with is_brj=1; cnt_mispred on each output transfer with redirect=1; both saturate at all-ones.
REQ-030 Counters SHALL NOT be affected by flush.

Reset
REQ-031 While rst=0: both stage valids, out_valid, redirect, taken, is_brj, link_wr, dest_addr and both counters SHALL be 0; in_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight entries; first accept is possible on the first edge after rst returns to 1.

Structure
REQ-033 Opcode constants and the WIDTH-agnostic opcode field positions SHALL live in shared package brj_pkg.
REQ-034 Combinational decode/target/condition logic SHALL be one sub-module brj_decode, instantiated in S1.

Verification (WIDTH=16, out_ready=1 unless stated)
REQ-035 BEQZ instr 0x600F, pc_inc 0xF0F0, rs_val 0, pred_npc 0xF0F0 -> 2 cycles later dest_addr 0xF0FF, taken 1, redirect 1, cnt_mispred 1.
REQ-036 BNEZ instr 0x6802, rs_val 0, pc_inc 0xF0F0, pred_npc 0xF0F0 -> dest_addr 0xF0F0, taken 0, redirect 0.
REQ-037 J instr 0x27FF, pc_inc 0xF0F0 -> dest_addr 0xF0EF; JALR instr 0x3880, rs_val 0x1000 -> dest_addr 0x0F80, link_wr 1; BEQZ imm 0x01, pc_inc 0xFFFF, rs_val 0 -> dest_addr 0x0000.
REQ-038 Back-to-back stream of 4 instructions with out_ready low for cycles 3-5 -> outputs held stable, in_ready low once both stages full, all 4 results delivered in order, none duplicated.
REQ-039 flush asserted together with in_valid while 2 entries in flight -> next cycle out_valid 0, no counter change, offered instruction never appears.
REQ-040 Assert rst=0 mid-stream -> all outputs and counters 0 immediately, without waiting for clk.
